// File: rtl/safe_pkg.sv
// Shared keypad/safe definitions: key codes, key map, scan states.
// Imported by the keypad scanner, the entry buffer and the safe FSM.
package safe_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    // A-D share one code: they are accepted but never change the entry
    localparam logic [3:0] KEY_LTR  = 4'hA;
    localparam logic [3:0] KEY_NONE = 4'hB;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    localparam logic [15:0] EMERGENCY_CODE = 16'h0119;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS_DB,
        ST_HELD,
        ST_REL_DB
    } scan_state_t;

    function automatic logic [3:0] key_lookup(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [3:0] code;
        case ({row, col})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hC: code = KEY_STAR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_HASH;
            4'h3, 4'h7, 4'hB, 4'hF: code = KEY_LTR;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_9;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad pins plus the entry-buffer interface towards the safe FSM.
// slave = keypad_entry, master = the side driving columns and clear.
interface keypad_entry_if;

    logic [3:0]  kp_col_n;
    logic        entry_clear;
    logic [3:0]  kp_row_n;
    logic [15:0] user_input_data;
    logic [2:0]  digit_count;
    logic        btn_input_done;
    logic        key_pulse;

    modport master (
        output kp_col_n,
        output entry_clear,
        input  kp_row_n,
        input  user_input_data,
        input  digit_count,
        input  btn_input_done,
        input  key_pulse
    );

    modport slave (
        input  kp_col_n,
        input  entry_clear,
        output kp_row_n,
        output user_input_data,
        output digit_count,
        output btn_input_done,
        output key_pulse
    );

endinterface

// File: rtl/keypad_entry_scanner.sv
// Row scanner with column synchronizer, slot divider and debounce FSM.
// key_evt strobes on the accepting tick; key_code is valid with it.
module keypad_scanner
    import safe_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] kp_col_n,
    output logic [3:0] kp_row_n,
    output logic       key_evt,
    output logic [3:0] key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       col_s1;
    logic [3:0]       col_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       row_idx;
    logic [1:0]       col_q;
    logic [1:0]       col_idx;
    logic             tick;
    logic             hit;
    logic             same;
    scan_state_t      state;

    assign tick = (div_cnt == DIV_MAX);

    // lowest-numbered low column wins
    always_comb begin
        hit     = ~&col_s2;
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_s2[c]) col_idx = 2'(c);
        end
    end

    assign same     = hit && (col_idx == col_q);
    assign key_evt  = tick && (state == ST_PRESS_DB)
                      && same && (cnt == CNT_LAST);
    assign key_code = key_lookup(row_idx, col_q);
    assign kp_row_n = ~(4'b0001 << row_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_s1  <= 4'hF;
            col_s2  <= 4'hF;
            div_cnt <= '0;
            cnt     <= '0;
            row_idx <= 2'd0;
            col_q   <= 2'd0;
            state   <= ST_SCAN;
        end else begin
            col_s1  <= kp_col_n;
            col_s2  <= col_s1;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                unique case (state)
                    ST_SCAN: begin
                        if (hit) begin
                            col_q <= col_idx;
                            cnt   <= CNT_ONE;
                            state <= ST_PRESS_DB;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end
                    ST_PRESS_DB: begin
                        if (!same) begin
                            cnt   <= '0;
                            state <= ST_SCAN;
                        end else if (cnt == CNT_LAST) begin
                            state <= ST_HELD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!hit) begin
                            cnt   <= CNT_ONE;
                            state <= ST_REL_DB;
                        end
                    end
                    ST_REL_DB: begin
                        if (hit) begin
                            state <= ST_HELD;
                        end else if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= ST_SCAN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// 4-digit BCD keypad entry feeding the safe FSM.
// KEYPAD_AUTOCLEAR_EN: clear the entry on the 2nd clk after done.
module keypad_entry
    import safe_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input logic           clk,
    input logic           rst_n,
    keypad_entry_if.slave bus
);

    logic        key_evt;
    logic [3:0]  key_code;
    logic [15:0] data;
    logic [2:0]  count;
    logic        done;
    logic        pulse;
`ifdef KEYPAD_AUTOCLEAR_EN
    logic        ac_pend;
`else
    logic        after_hash;
`endif

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .kp_col_n (bus.kp_col_n),
        .kp_row_n (bus.kp_row_n),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    assign bus.user_input_data = data;
    assign bus.digit_count     = count;
    assign bus.btn_input_done  = done;
    assign bus.key_pulse       = pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            count <= '0;
            done  <= 1'b0;
            pulse <= 1'b0;
`ifdef KEYPAD_AUTOCLEAR_EN
            ac_pend <= 1'b0;
`else
            after_hash <= 1'b0;
`endif
        end else begin
            pulse <= key_evt;
            done  <= 1'b0;
`ifdef KEYPAD_AUTOCLEAR_EN
            ac_pend <= done;
`endif
            if (bus.entry_clear) begin
                data  <= '0;
                count <= '0;
`ifndef KEYPAD_AUTOCLEAR_EN
                after_hash <= 1'b0;
`endif
`ifdef KEYPAD_AUTOCLEAR_EN
            end else if (ac_pend) begin
                data  <= '0;
                count <= '0;
`endif
            end else if (key_evt) begin
                unique case (1'b1)
                    is_digit(key_code): begin
`ifndef KEYPAD_AUTOCLEAR_EN
                        // first digit after '#' starts a new entry
                        if (after_hash) begin
                            data       <= {12'h000, key_code};
                            count      <= 3'd1;
                            after_hash <= 1'b0;
                        end else
`endif
                        if (count < 3'd4) begin
                            data  <= {data[11:0], key_code};
                            count <= count + 3'd1;
                        end
                    end
                    key_code == KEY_STAR: begin
                        data  <= '0;
                        count <= '0;
`ifndef KEYPAD_AUTOCLEAR_EN
                        after_hash <= 1'b0;
`endif
                    end
                    key_code == KEY_HASH: begin
                        done <= 1'b1;
`ifndef KEYPAD_AUTOCLEAR_EN
                        after_hash <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized scoreboard bench for keypad_entry.
// Keypad model pulls a column low while its row is driven low.
module tb_keypad_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
`ifdef KEYPAD_AUTOCLEAR_EN
    localparam bit AC = 1'b1;
`else
    localparam bit AC = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        int          count;
        bit          done;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_if bus();

    keypad_entry #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic       pressed = 1'b0;
    int         prow    = 0;
    int         pcol    = 0;
    logic [3:0] col_drv;

    always_comb begin
        col_drv = 4'hF;
        if (pressed && !bus.kp_row_n[prow]) col_drv[pcol] = 1'b0;
    end
    assign bus.kp_col_n = col_drv;

    string KEYS = "123A456B789C*0#D";
    exp_t  sb[$];
    int    digits[$];
    bit    after_hash = 1'b0;
    int    tests      = 0;
    int    fails      = 0;
    int    done_exp   = 0;
    int    done_seen  = 0;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack();
        logic [15:0] d;
        d = 16'h0;
        foreach (digits[i]) d = (d << 4) | 16'(digits[i]);
        return d;
    endfunction

    // entry semantics expressed on a list of typed digits
    function automatic exp_t model_key(byte ch, bit clr);
        exp_t e;
        e.done = 1'b0;
        if (clr) begin
            digits.delete();
            after_hash = 1'b0;
        end else if (ch >= "0" && ch <= "9") begin
            if (after_hash && !AC) begin
                digits.delete();
                after_hash = 1'b0;
            end
            if (digits.size() < 4) digits.push_back(int'(ch) - 48);
        end else if (ch == "*") begin
            digits.delete();
            after_hash = 1'b0;
        end else if (ch == "#") begin
            e.done = 1'b1;
            after_hash = 1'b1;
            done_exp++;
        end
        e.data  = pack();
        e.count = digits.size();
        if (ch == "#" && !clr && AC) begin
            digits.delete();
            after_hash = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_rc(int r, int c, int hold, int rel, bit clr);
        sb.push_back(model_key(KEYS[r*4+c], clr));
        bus.entry_clear = clr;
        prow    = r;
        pcol    = c;
        pressed = 1'b1;
        wait_clk(hold * SCAN_DIV);
        pressed = 1'b0;
        bus.entry_clear = 1'b0;
        wait_clk(rel * SCAN_DIV);
    endtask

    task automatic press(byte ch);
        for (int i = 0; i < 16; i++) begin
            if (KEYS[i] == ch) press_rc(i / 4, i % 4, 10, 10, 1'b0);
        end
    endtask

    task automatic wait_row_enter(int r);
        int n;
        n = 0;
        while (!bus.kp_row_n[r] && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (bus.kp_row_n[r] && n < 128) begin
            @(negedge clk);
            n++;
        end
        chk("row_reached", int'(bus.kp_row_n[r]), 0);
    endtask

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.btn_input_done) done_seen++;
            if (rst_n && bus.key_pulse) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pulse: unexpected key_pulse at %0t",
                             $time);
                end else begin
                    e = sb.pop_front();
                    chk("data", int'(bus.user_input_data), int'(e.data));
                    chk("count", int'(bus.digit_count), e.count);
                    chk("done", int'(bus.btn_input_done), int'(e.done));
                    if (AC && e.done) begin
                        @(negedge clk);
                        chk("ac_hold", int'(bus.user_input_data),
                            int'(e.data));
                        @(negedge clk);
                        chk("ac_clear", int'(bus.user_input_data), 0);
                        chk("ac_count", int'(bus.digit_count), 0);
                    end
                end
            end else if (rst_n && bus.btn_input_done) begin
                tests++;
                fails++;
                $display("FAIL done: pulse without key_pulse at %0t",
                         $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0] row0;
        bus.entry_clear = 1'b0;
        wait_clk(3);
        chk("rst_row", int'(bus.kp_row_n), 4'hE);
        chk("rst_data", int'(bus.user_input_data), 0);
        chk("rst_count", int'(bus.digit_count), 0);
        chk("rst_pulse", int'(bus.key_pulse), 0);
        chk("rst_done", int'(bus.btn_input_done), 0);
        rst_n = 1'b1;
        wait_clk(2);

        press("1"); press("1"); press("9"); press("#");
        chk("t1_data", int'(bus.user_input_data),
            AC ? 0 : int'(safe_pkg::EMERGENCY_CODE));
        chk("t1_count", int'(bus.digit_count), AC ? 0 : 3);

        press("1"); press("2"); press("3"); press("4"); press("5");
        chk("t2_data", int'(bus.user_input_data), 16'h1234);
        chk("t2_count", int'(bus.digit_count), 4);
        press("#"); press("7");
        chk("t2_restart", int'(bus.user_input_data), 16'h0007);
        chk("t2_rcount", int'(bus.digit_count), 1);

        // short glitch on key '8' must be rejected
        wait_row_enter(2);
        prow    = 2;
        pcol    = 1;
        pressed = 1'b1;
        wait_clk(2 * SCAN_DIV);
        pressed = 1'b0;
        wait_clk(6 * SCAN_DIV);
        row0 = bus.kp_row_n;
        wait_clk(SCAN_DIV);
        chk("t3_rotating", int'(bus.kp_row_n != row0), 1);
        chk("t3_data", int'(bus.user_input_data), int'(pack()));

        press_rc(1, 1, 100, 10, 1'b0);

        press("4"); press("2"); press("*");
        chk("t4_data", int'(bus.user_input_data), 0);
        chk("t4_count", int'(bus.digit_count), 0);
        press("6");
        press("A");
        chk("t4_letter", int'(bus.user_input_data), 16'h0006);

        // reset during the debounce of a held '1'
        wait_row_enter(0);
        prow    = 0;
        pcol    = 0;
        pressed = 1'b1;
        wait_clk(6);
        rst_n = 1'b0;
        wait_clk(1);
        chk("t5_row", int'(bus.kp_row_n), 4'hE);
        chk("t5_data", int'(bus.user_input_data), 0);
        chk("t5_count", int'(bus.digit_count), 0);
        chk("t5_pulse", int'(bus.key_pulse), 0);
        digits.delete();
        after_hash = 1'b0;
        sb.push_back(model_key("1", 1'b0));
        rst_n = 1'b1;
        wait_clk((DEB + 2) * SCAN_DIV);
        chk("t5_reaccept", int'(bus.digit_count), 1);
        pressed = 1'b0;
        wait_clk(10 * SCAN_DIV);

        press("4");
        press_rc(1, 1, 10, 10, 1'b1);
        chk("t6_data", int'(bus.user_input_data), 0);
        press("3");
        press_rc(3, 2, 10, 10, 1'b1);
        press("9"); press("#");

        for (int n = 0; n < 24; n++) begin
            press_rc(int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)),
                     int'($urandom_range(14, 10)),
                     int'($urandom_range(13, 10)),
                     1'b0);
        end

        wait_clk(10 * SCAN_DIV);
        chk("sb_drained", sb.size(), 0);
        chk("done_total", done_seen, done_exp);
        chk("final_data", int'(bus.user_input_data), int'(pack()));
        chk("final_count", int'(bus.digit_count), digits.size());
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
